// File: rtl/svadc_wrapper.sv
// svadc_wrapper: DE0-Nano top that captures a 10-bit parallel ADC on GPIO_1,
// tracks running min/max and shows a switch-selected view on the LEDs.
module svadc_wrapper (
    input  logic        CLOCK_50,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic [1:0]  DRAM_DQM,
    output logic        DRAM_CKE,
    output logic        DRAM_CLK,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    inout  wire  [15:0] DRAM_DQ,
    inout  wire         I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic        G_SENSOR_CS_N,
    input  logic        G_SENSOR_INT,
    output logic        ADC_CS_N,
    output logic        ADC_SADDR,
    output logic        ADC_SCLK,
    input  logic        ADC_SDAT,
    inout  wire  [33:0] GPIO_0,
    input  logic [1:0]  GPIO_0_IN,
    inout  wire  [33:0] GPIO_1,
    input  logic [1:0]  GPIO_1_IN,
    inout  wire  [12:0] GPIO_2,
    input  logic [2:0]  GPIO_2_IN
);
    logic        rst_n;
    logic        adc_clk;
    logic        sample_valid;
    logic [9:0]  adc_d;
    logic [9:0]  sample;
    logic [9:0]  min_val;
    logic [9:0]  max_val;
    logic [1:0]  clr_sync;
    logic [1:0]  sw_r;
    logic [23:0] heartbeat;
    logic [7:0]  view;
    logic        unused;

    assign rst_n = KEY[0];
    // The ADC board's data lines are scattered across the header.
    assign adc_d = {GPIO_1[32], GPIO_1[30], GPIO_1[31], GPIO_1[29], GPIO_1[33],
                    GPIO_1[27], GPIO_1[25], GPIO_1[19], GPIO_1[23], GPIO_1[21]};

    assign GPIO_0   = 'z;
    assign GPIO_1   = {15'bz, adc_clk, 18'bz};
    assign GPIO_2   = 'z;
    assign DRAM_DQ  = 'z;
    assign I2C_SCLK = 1'bz;
    assign I2C_SDAT = 1'bz;

    assign DRAM_CLK      = CLOCK_50;
    assign DRAM_CKE      = 1'b1;
    assign DRAM_CS_N     = 1'b1;
    assign DRAM_RAS_N    = 1'b1;
    assign DRAM_CAS_N    = 1'b1;
    assign DRAM_WE_N     = 1'b1;
    assign DRAM_ADDR     = '0;
    assign DRAM_BA       = '0;
    assign DRAM_DQM      = 2'b11;
    assign G_SENSOR_CS_N = 1'b1;
    assign ADC_CS_N      = 1'b1;
    assign ADC_SADDR     = 1'b0;
    assign ADC_SCLK      = 1'b0;

    assign unused = &{1'b0, SW[3:2], G_SENSOR_INT, ADC_SDAT, GPIO_0, GPIO_0_IN,
                      GPIO_1, GPIO_1_IN, GPIO_2, GPIO_2_IN, DRAM_DQ, I2C_SCLK, I2C_SDAT};

    always_comb
        view = sw_r == 2'b00 ? sample[9:2] :
               sw_r == 2'b01 ? min_val[9:2] :
               sw_r == 2'b10 ? max_val[9:2] : heartbeat[23:16];

    always_ff @(posedge CLOCK_50 or negedge rst_n)
        if (!rst_n) begin
            adc_clk      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            min_val      <= 10'h3FF;
            max_val      <= '0;
            clr_sync     <= 2'b11;
            sw_r         <= '0;
            heartbeat    <= '0;
            LED          <= '0;
        end else begin
            adc_clk      <= ~adc_clk;
            sample_valid <= adc_clk;
            if (adc_clk)
                sample <= adc_d;
            clr_sync  <= {clr_sync[0], KEY[1]};
            sw_r      <= SW[1:0];
            heartbeat <= heartbeat + 24'd1;
            LED       <= view;
            // Clear takes priority over a sample arriving in the same cycle.
            if (!clr_sync[1]) begin
                min_val <= 10'h3FF;
                max_val <= '0;
            end else if (sample_valid) begin
                min_val <= sample < min_val ? sample : min_val;
                max_val <= sample > max_val ? sample : max_val;
            end
        end
endmodule

// File: tb/tb_svadc_wrapper.sv
// tb_svadc_wrapper: directed bench for svadc_wrapper with hand-computed LED views.
module tb_svadc_wrapper;
    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [3:0]  sw;
    logic [9:0]  adc_d;
    logic [15:0] dq_drv;
    logic        prev_clk;
    int          compared = 0;
    int          mismatched = 0;

    wire [7:0]  led;
    wire [12:0] dram_addr;
    wire [1:0]  dram_ba, dram_dqm;
    wire        dram_cke, dram_clk, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
    wire [15:0] dram_dq;
    wire        i2c_sclk, i2c_sdat;
    wire        g_sensor_cs_n;
    wire        adc_cs_n, adc_saddr, adc_sclk;
    wire [33:0] gpio_0, gpio_1;
    wire [12:0] gpio_2;

    always #10 clk = ~clk;

    assign dram_dq    = dq_drv;
    assign gpio_1[32] = adc_d[9];
    assign gpio_1[30] = adc_d[8];
    assign gpio_1[31] = adc_d[7];
    assign gpio_1[29] = adc_d[6];
    assign gpio_1[33] = adc_d[5];
    assign gpio_1[27] = adc_d[4];
    assign gpio_1[25] = adc_d[3];
    assign gpio_1[19] = adc_d[2];
    assign gpio_1[23] = adc_d[1];
    assign gpio_1[21] = adc_d[0];

    svadc_wrapper dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LED(led),
        .DRAM_ADDR(dram_addr), .DRAM_BA(dram_ba), .DRAM_DQM(dram_dqm),
        .DRAM_CKE(dram_cke), .DRAM_CLK(dram_clk), .DRAM_CS_N(dram_cs_n),
        .DRAM_RAS_N(dram_ras_n), .DRAM_CAS_N(dram_cas_n), .DRAM_WE_N(dram_we_n),
        .DRAM_DQ(dram_dq), .I2C_SCLK(i2c_sclk), .I2C_SDAT(i2c_sdat),
        .G_SENSOR_CS_N(g_sensor_cs_n), .G_SENSOR_INT(1'b0),
        .ADC_CS_N(adc_cs_n), .ADC_SADDR(adc_saddr), .ADC_SCLK(adc_sclk), .ADC_SDAT(1'b0),
        .GPIO_0(gpio_0), .GPIO_0_IN(2'b00), .GPIO_1(gpio_1), .GPIO_1_IN(2'b00),
        .GPIO_2(gpio_2), .GPIO_2_IN(3'b000)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        key    = 2'b10;
        sw     = 4'b0000;
        adc_d  = 10'h200;
        dq_drv = 16'h1234;
        #100;
        @(negedge clk);
        check("reset_led", {24'd0, led}, 32'h00);
        check("reset_adc_clk", {31'd0, gpio_1[18]}, 32'd0);
        check("idle_pins", {27'd0, dram_cs_n, g_sensor_cs_n, adc_cs_n, adc_saddr, adc_sclk},
              32'b11100);
        check("idle_dram_ctl", {11'd0, dram_addr, dram_ba, dram_dqm, dram_cke,
              dram_ras_n, dram_cas_n, dram_we_n}, {11'd0, 13'd0, 2'd0, 2'b11, 4'b1111});
        check("dq_readback_0", {16'd0, dram_dq}, 32'h1234);
        check("dram_clk_low", {31'd0, dram_clk}, 32'd0);

        key[0] = 1'b1;
        cycles(4);
        check("first_view00", {24'd0, led}, 32'h80);
        prev_clk = gpio_1[18];
        cycles(1);
        check("adc_clk_toggle", {31'd0, gpio_1[18]}, {31'd0, ~prev_clk});
        @(posedge clk); #1;
        check("dram_clk_high", {31'd0, dram_clk}, 32'd1);
        @(negedge clk);

        sw = 4'b0001;
        cycles(3);
        check("min_200", {24'd0, led}, 32'h80);
        sw = 4'b0010;
        cycles(3);
        check("max_200", {24'd0, led}, 32'h80);

        adc_d = 10'h100;
        cycles(4);
        adc_d = 10'h3FC;
        cycles(4);
        adc_d = 10'h200;
        cycles(4);
        sw = 4'b0001;
        cycles(3);
        check("min_seq", {24'd0, led}, 32'h40);
        sw = 4'b0010;
        cycles(3);
        check("max_seq", {24'd0, led}, 32'hFF);
        sw = 4'b0000;
        cycles(3);
        check("sample_seq", {24'd0, led}, 32'h80);

        dq_drv = 16'hA5C3;
        #1;
        check("dq_readback_1", {16'd0, dram_dq}, 32'hA5C3);

        adc_d = 10'h080;
        sw = 4'b0010;
        cycles(3);
        key[1] = 1'b0;
        cycles(4);
        check("max_during_clear", {24'd0, led}, 32'h00);
        cycles(1);
        key[1] = 1'b1;
        cycles(8);
        check("max_after_clear", {24'd0, led}, 32'h20);
        sw = 4'b0001;
        cycles(3);
        check("min_after_clear", {24'd0, led}, 32'h20);

        sw = 4'b0011;
        #3;
        key[0] = 1'b0;
        #1;
        check("midrun_reset_led", {24'd0, led}, 32'h00);
        check("midrun_reset_adc_clk", {31'd0, gpio_1[18]}, 32'd0);
        @(negedge clk);
        key[0] = 1'b1;
        cycles(65536);
        check("heartbeat_before_step", {24'd0, led}, 32'h00);
        cycles(1);
        check("heartbeat_step", {24'd0, led}, 32'h01);
        dq_drv = 16'h0F0F;
        #1;
        check("dq_readback_2", {16'd0, dram_dq}, 32'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
